// File: rtl/ysyx_22040759_rf_warb_pkg.sv
// Shared definitions for the register-file write arbiter.
//   - ws_to_rf_bus field offsets: [69] wen, [68:64] waddr, [63:0] wdata
//   - register file geometry
//   - arbiter FSM state encoding (also exported on the debug port)
package ysyx_22040759_rf_warb_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 64;

  localparam int WS_BUS_W    = 70;
  localparam int WS_WEN_BIT  = 69;
  localparam int WS_WADDR_HI = 68;
  localparam int WS_WADDR_LO = 64;
  localparam int WS_WDATA_HI = 63;
  localparam int WS_WDATA_LO = 0;

  // IDLE : buffer empty, WB passes straight through
  // HOLD : buffer full, WB keeps priority while the starve counter runs
  // FORCE: buffer full and starved too long, WB is stalled for one cycle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } warb_state_t;

endpackage

// File: rtl/ysyx_22040759_rf_wbuf.sv
// Single-entry holding buffer for mul/div results.
//   clk, rst          : clock, synchronous active-high reset
//   push_valid/ready  : producer handshake; ready is !buf_valid straight from a flop
//   push_rd/push_data : destination register and result
//   pop               : consumer drained the entry this cycle
//   buf_rd/buf_data   : current buffered entry (meaningful while push_ready is 0)
// Handshake: a transfer happens on a rising edge where push_valid && push_ready.
// A result aimed at x0 completes the handshake but is dropped.
module ysyx_22040759_rf_wbuf
  import ysyx_22040759_rf_warb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [RF_ADDR_W-1:0] push_rd,
  input  logic [RF_DATA_W-1:0] push_data,
  input  logic                 pop,
  output logic [RF_ADDR_W-1:0] buf_rd,
  output logic [RF_DATA_W-1:0] buf_data
);

  logic buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end else if (push_valid && push_ready && (push_rd != '0)) begin
      buf_valid <= 1'b1;
      buf_rd    <= push_rd;
      buf_data  <= push_data;
    end
  end

  // Pop and push never coincide: pop only happens while full, when ready is 0.
  assign push_ready = !buf_valid;

endmodule

// File: rtl/ysyx_22040759_rf_warb.sv
// Register-file write-port arbiter between the WB stage and the mul/div unit.
//   clk, rst        : clock, synchronous active-high reset
//   ws_to_rf_bus    : WB write request {wen, waddr[4:0], wdata[63:0]}
//   md_valid/ready  : mul/div result handshake (ready is registered)
//   md_rd/md_result : mul/div destination and value
//   ws_stall        : asks WB to hold its current write for a cycle
//   rf_wen/waddr/wdata : register file write port
//   dbg_state       : current arbiter state
// WB normally wins the port. A buffered mul/div result drains on any cycle WB
// does not write; after STARVE_MAX consecutive losses WB is stalled once so the
// buffer is guaranteed to drain.
module ysyx_22040759_rf_warb
  import ysyx_22040759_rf_warb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WS_BUS_W-1:0]  ws_to_rf_bus,
  input  logic                 md_valid,
  input  logic [RF_ADDR_W-1:0] md_rd,
  input  logic [RF_DATA_W-1:0] md_result,
  output logic                 md_ready,
  output logic                 ws_stall,
  output logic                 rf_wen,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [RF_DATA_W-1:0] rf_wdata,
  output warb_state_t          dbg_state
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  warb_state_t state, state_nxt, cur;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic                 buf_pop;
  logic [RF_ADDR_W-1:0] buf_rd;
  logic [RF_DATA_W-1:0] buf_data;

  logic                 ws_wen;
  logic [RF_ADDR_W-1:0] ws_waddr;
  logic [RF_DATA_W-1:0] ws_wdata;
  logic                 sel_wen;
  logic [RF_ADDR_W-1:0] sel_addr;
  logic [RF_DATA_W-1:0] sel_data;

  assign ws_wen   = ws_to_rf_bus[WS_WEN_BIT];
  assign ws_waddr = ws_to_rf_bus[WS_WADDR_HI:WS_WADDR_LO];
  assign ws_wdata = ws_to_rf_bus[WS_WDATA_HI:WS_WDATA_LO];

  ysyx_22040759_rf_wbuf u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push_valid (md_valid),
    .push_ready (md_ready),
    .push_rd    (md_rd),
    .push_data  (md_result),
    .pop        (buf_pop),
    .buf_rd     (buf_rd),
    .buf_data   (buf_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // While reset is held the port behaves as IDLE so a buffered result is
  // discarded instead of being written during the reset cycle.
  assign cur = rst ? ST_IDLE : state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    buf_pop   = 1'b0;
    ws_stall  = 1'b0;
    sel_wen   = ws_wen;
    sel_addr  = ws_waddr;
    sel_data  = ws_wdata;
    case (cur)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (md_valid && md_ready && (md_rd != '0))
          state_nxt = (STARVE_MAX < 1) ? ST_FORCE : ST_HOLD;
      end
      ST_HOLD: begin
        if (ws_wen) begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          if (cnt_nxt == CNT_MAX)
            state_nxt = ST_FORCE;
        end else begin
          sel_wen   = 1'b1;
          sel_addr  = buf_rd;
          sel_data  = buf_data;
          buf_pop   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_FORCE: begin
        // WB write is dropped this cycle; the stall makes WB replay it next cycle.
        ws_stall  = 1'b1;
        sel_wen   = 1'b1;
        sel_addr  = buf_rd;
        sel_data  = buf_data;
        buf_pop   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // x0 is hardwired zero: never raise a write towards it.
  assign rf_wen    = sel_wen && (sel_addr != '0);
  assign rf_waddr  = sel_addr;
  assign rf_wdata  = sel_data;
  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_22040759_rf_warb.sv
module tb_ysyx_22040759_rf_warb;
  import ysyx_22040759_rf_warb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [69:0] ws_to_rf_bus;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [63:0] md_result;
  logic        md_ready;
  logic        ws_stall;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  warb_state_t dbg_state;

  ysyx_22040759_rf_warb #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .ws_to_rf_bus (ws_to_rf_bus),
    .md_valid     (md_valid),
    .md_rd        (md_rd),
    .md_result    (md_result),
    .md_ready     (md_ready),
    .ws_stall     (ws_stall),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [68:0] exp_q[$];   // {waddr, wdata} of every RF write expected, in order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Every RF write the DUT makes must match the head of the expected queue.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rf_write_unexpected actual=%0d:0x%0h required=none", rf_waddr, rf_wdata);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          failures++;
          $display("FAIL rf_write actual=%0d:0x%0h required=%0d:0x%0h",
                   rf_waddr, rf_wdata, e[68:64], e[63:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_ws(input logic wen, input logic [4:0] addr, input logic [63:0] data);
    ws_to_rf_bus = {wen, addr, data};
  endtask

  task automatic drive_md(input logic v, input logic [4:0] rd, input logic [63:0] res);
    md_valid  = v;
    md_rd     = rd;
    md_result = res;
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [63:0] data);
    exp_q.push_back({addr, data});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'h1234,               1'b1, 5'd5,  64'h1234};
    vecs[1] = '{1'b1, 5'd0,  64'hAB,                 1'b0, 5'd0,  64'h0};
    vecs[2] = '{1'b0, 5'd9,  64'h99,                 1'b0, 5'd0,  64'h0};
    vecs[3] = '{1'b1, 5'd31, 64'hFFFF_0000_CAFE_F00D, 1'b1, 5'd31, 64'hFFFF_0000_CAFE_F00D};
    vecs[4] = '{1'b1, 5'd1,  64'h1,                  1'b1, 5'd1,  64'h1};

    rst = 1'b1;
    drive_ws(1'b0, 5'd0, 64'h0);
    drive_md(1'b0, 5'd0, 64'h0);
    repeat (2) @(posedge clk);
    #1;

    // reset state
    mid();
    chk("reset_md_ready", md_ready, 1);
    chk("reset_ws_stall", ws_stall, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    chk("reset_rf_wen", rf_wen, 0);
    next();
    rst = 1'b0;

    // IDLE passthrough, table driven
    for (int i = 0; i < 5; i++) begin
      drive_ws(vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
      if (vecs[i].exp_wen) expect_wr(vecs[i].exp_waddr, vecs[i].exp_wdata);
      mid();
      chk($sformatf("vec%0d_rf_wen", i), rf_wen, vecs[i].exp_wen);
      if (vecs[i].exp_wen) begin
        chk($sformatf("vec%0d_rf_waddr", i), rf_waddr, vecs[i].exp_waddr);
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
      end
      chk($sformatf("vec%0d_ws_stall", i), ws_stall, 0);
      next();
    end

    // IDLE passthrough, random
    for (int i = 0; i < 8; i++) begin
      logic        w;
      logic [4:0]  a;
      logic [63:0] d;
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d = {32'($urandom), 32'($urandom)};
      drive_ws(w, a, d);
      if (w && a != 5'd0) expect_wr(a, d);
      mid();
      chk("rand_rf_wen", rf_wen, (w && a != 5'd0));
      next();
    end
    drive_ws(1'b0, 5'd0, 64'h0);

    // single md result with WB idle: latency 1
    drive_md(1'b1, 5'd7, 64'hDEAD);
    mid();
    chk("md_ready_before", md_ready, 1);
    next();
    drive_md(1'b0, 5'd0, 64'h0);
    expect_wr(5'd7, 64'hDEAD);
    mid();
    chk("md_ready_full", md_ready, 0);
    chk("md_state_hold", dbg_state, ST_HOLD);
    chk("md_drain_wen", rf_wen, 1);
    next();
    mid();
    chk("md_ready_after", md_ready, 1);
    chk("md_state_idle", dbg_state, ST_IDLE);
    next();

    // md result to x0 is dropped
    drive_md(1'b1, 5'd0, 64'hFF);
    mid();
    chk("x0_md_ready", md_ready, 1);
    next();
    drive_md(1'b0, 5'd0, 64'h0);
    mid();
    chk("x0_md_ready_next", md_ready, 1);
    chk("x0_rf_wen", rf_wen, 0);
    chk("x0_state", dbg_state, ST_IDLE);
    next();

    // drain cycle with a new md_valid waiting: accepted one cycle later
    drive_md(1'b1, 5'd8, 64'h11);
    next();
    drive_md(1'b1, 5'd9, 64'h22);
    expect_wr(5'd8, 64'h11);
    mid();
    chk("b2b_ready_drain", md_ready, 0);
    chk("b2b_state_hold", dbg_state, ST_HOLD);
    next();
    mid();
    chk("b2b_ready_retry", md_ready, 1);
    chk("b2b_rf_wen_idle", rf_wen, 0);
    chk("b2b_state_idle", dbg_state, ST_IDLE);
    next();
    drive_md(1'b0, 5'd0, 64'h0);
    expect_wr(5'd9, 64'h22);
    mid();
    chk("b2b_state_hold2", dbg_state, ST_HOLD);
    next();
    mid();
    chk("b2b_state_idle2", dbg_state, ST_IDLE);
    next();

    // starvation: WB writes every cycle, buffer forced after 4 losses
    drive_md(1'b1, 5'd3, 64'hBEEF);
    next();
    drive_md(1'b0, 5'd0, 64'h0);
    begin
      int k;
      k = 0;
      for (int c = 0; c <= 10; c++) begin
        logic exp_stall;
        exp_stall = (c == 4);
        drive_ws(1'b1, 5'(10 + k), 64'h100 + 64'(k));
        if (exp_stall) expect_wr(5'd3, 64'hBEEF);
        else           expect_wr(5'(10 + k), 64'h100 + 64'(k));
        mid();
        chk($sformatf("starve_c%0d_ws_stall", c), ws_stall, exp_stall);
        chk($sformatf("starve_c%0d_md_ready", c), md_ready, (c >= 5));
        if (c == 4) chk("starve_state_force", dbg_state, ST_FORCE);
        next();
        if (!exp_stall) k++;
      end
    end
    drive_ws(1'b0, 5'd0, 64'h0);

    // reset while HOLD discards the buffered result
    drive_md(1'b1, 5'd12, 64'h5555);
    next();
    drive_md(1'b0, 5'd0, 64'h0);
    drive_ws(1'b1, 5'd4, 64'h44);
    expect_wr(5'd4, 64'h44);
    mid();
    chk("rst_hold_state", dbg_state, ST_HOLD);
    next();
    drive_ws(1'b0, 5'd0, 64'h0);
    rst = 1'b1;
    mid();
    chk("rst_cycle_rf_wen", rf_wen, 0);
    next();
    rst = 1'b0;
    mid();
    chk("rst_after_state", dbg_state, ST_IDLE);
    chk("rst_after_md_ready", md_ready, 1);
    chk("rst_after_rf_wen", rf_wen, 0);
    repeat (3) begin
      next();
      mid();
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_rf_warb.md
YSYX_22040759_RF_WARB -- requirements
Module: ysyx_22040759_rf_warb

Interface
REQ-001 Parameter: STARVE_MAX, default 4, meaning cycles a buffered multi-cycle result may lose arbitration before WB is stalled.
REQ-002 clk  input  1  core clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ws_to_rf_bus  input  70  WB write request: [69] wen (already qualified by ws_valid), [68:64] waddr, [63:0] wdata.
REQ-005 md_valid  input  1  mul/div unit result valid.
REQ-006 md_rd  input  5  mul/div destination register.
REQ-007 md_result  input  64  mul/div result.
REQ-008 md_ready  output  1  arbiter accepts md result this cycle.
REQ-009 ws_stall  output  1  WB hold request; WB drives ws_ready_go = !ws_stall.
REQ-010 rf_wen  output  1  register file write enable.
REQ-011 rf_waddr  output  5  register file write address.
REQ-012 rf_wdata  output  64  register file write data.

Function
REQ-013 Single-entry result buffer (buf_valid, buf_rd, buf_data); md handshake completes when md_valid && md_ready.
REQ-014 md_ready SHALL equal !buf_valid, a registered value with no combinational path from any input.
REQ-015 Accepted md result SHALL be captured into the buffer at the next edge; earliest RF write is the following cycle (latency 1).
REQ-016 md result with md_rd == 0 SHALL be accepted and discarded (buf_valid stays 0).
REQ-017 States: IDLE (buffer empty), HOLD (buffer full, WB has priority), FORCE (buffer full, starvation limit reached).
REQ-018 IDLE: rf_* SHALL pass ws_to_rf_bus through combinationally (zero latency); ws_stall = 0.
REQ-019 HOLD, WB wen = 1: WB wins; starve counter increments by 1; buffer kept.
REQ-020 HOLD, WB wen = 0: buffer written (rf_wen = 1, rf_waddr = buf_rd, rf_wdata = buf_data); buffer clears; counter clears; next state IDLE.
REQ-021 HOLD -> FORCE when counter reaches STARVE_MAX at an edge with buffer still full.
REQ-022 FORCE: ws_stall = 1; buffer written regardless of WB wen; WB write suppressed this cycle (held WB retries next cycle); buffer and counter clear; next state IDLE.
REQ-023 rf_wen SHALL be 0 whenever rf_waddr would be 0.
REQ-024 Simultaneous buffer drain and new md_valid: md_ready is 0 that cycle (registered); new result is accepted the following cycle.
REQ-025 Counter width SHALL be clog2(STARVE_MAX+1) bits and saturate at STARVE_MAX.
REQ-026 Ordering hazards between md_rd and younger WB writes to the same register are resolved upstream by the issue scoreboard; this block does not check them.

Reset
REQ-027 On rst: state IDLE, buf_valid 0, counter 0, md_ready 1 after reset, ws_stall 0; rf_wen follows REQ-018 passthrough.
REQ-028 Reset mid-HOLD/FORCE SHALL discard the buffered result with no RF write.

Structure
REQ-029 State encoding and the ws_to_rf_bus field offsets (69, 68:64, 63:0) belong in ysyx_22040759_define.v.
REQ-030 One sub-module is natural: ysyx_22040759_rf_wbuf (single-entry result buffer with valid/ready); the FSM and mux stay in the top.

Verification
REQ-031 IDLE, WB wen=1 waddr=5 wdata=0x1234 -> same cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234.
REQ-032 md_valid md_rd=7 result=0xDEAD, WB idle -> md_ready drops next cycle; that cycle rf_waddr=7, rf_wdata=0xDEAD; md_ready=1 the cycle after.
REQ-033 Buffer full, WB wen=1 for 10 cycles, STARVE_MAX=4 -> 4 WB writes, then 1 cycle ws_stall=1 writing buffer, WB write completes the next cycle.
REQ-034 md_rd=0 result=0xFF -> accepted, no rf_wen asserted, md_ready stays 1.
REQ-035 rst asserted during HOLD -> next cycle IDLE, buf_valid 0, no buffered write ever appears.
REQ-036 WB waddr=0 wen=1 -> rf_wen=0.
